// File: rtl/branch_ctrl_if.sv
// Signal bundle between the ID-stage branch sequencer and its neighbours
// (target generator, hazard sources, PC/fetch redirect and counters).
interface branch_ctrl_if;
   logic        flush;
   logic        id_valid;
   logic        id_is_branch;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic        id_uses_rt;
   logic        ex_write;
   logic        ex_load;
   logic [4:0]  ex_write_addr;
   logic        mem_load;
   logic [4:0]  mem_write_addr;
   logic        branch_flag;
   logic [31:0] branch_addr;
   logic        if_ready;
   logic        id_stall;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_addr;
   logic [15:0] taken_cnt;
   logic [15:0] stall_cnt;

   modport master (
      output flush, id_valid, id_is_branch, id_rs_addr, id_rt_addr, id_uses_rt,
             ex_write, ex_load, ex_write_addr, mem_load, mem_write_addr,
             branch_flag, branch_addr, if_ready,
      input  id_stall, pc_redirect_valid, pc_redirect_addr, taken_cnt, stall_cnt
   );

   modport slave (
      input  flush, id_valid, id_is_branch, id_rs_addr, id_rt_addr, id_uses_rt,
             ex_write, ex_load, ex_write_addr, mem_load, mem_write_addr,
             branch_flag, branch_addr, if_ready,
      output id_stall, pc_redirect_valid, pc_redirect_addr, taken_cnt, stall_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls on operand hazards, hands the redirect to
// fetch with a ready handshake, and counts taken branches and stall cycles.
module branch_ctrl (
   input  logic         clk,
   input  logic         rst,
   branch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HAZARD  = 2'd1,
      PENDING = 2'd2
   } state_t;

   state_t      state;
   logic        cnt;
   logic [31:0] pend_addr;
   logic [15:0] taken_cnt;
   logic [15:0] stall_cnt;

   logic        is_branch;
   logic        ex_hit;
   logic        mem_hit;
   logic [1:0]  need;
   logic        id_stall;
   logic        redirect_valid;
   logic [31:0] redirect_addr;

   // Register 0 is hard-wired, so a write to it never creates a hazard.
   function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
      return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
   endfunction

   assign is_branch = bus.id_valid & bus.id_is_branch;
   assign ex_hit    = src_hit(bus.ex_write_addr, bus.id_rs_addr, bus.id_rt_addr, bus.id_uses_rt);
   assign mem_hit   = src_hit(bus.mem_write_addr, bus.id_rs_addr, bus.id_rt_addr, bus.id_uses_rt);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      need = 2'd0;
      if (is_branch) begin
         if (bus.ex_load && ex_hit)       need = 2'd2;
         else if (bus.ex_write && ex_hit) need = 2'd1;
         if (bus.mem_load && mem_hit && (need == 2'd0)) need = 2'd1;
      end
   end

   // Redirect and stall are combinational so a clean taken branch costs no cycle.
   always_comb begin
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 32'd0;
      if (!bus.flush) begin
         case (state)
            IDLE: begin
               if (need != 2'd0) begin
                  id_stall = 1'b1;
               end else if (is_branch && bus.branch_flag) begin
                  redirect_valid = 1'b1;
                  redirect_addr  = bus.branch_addr;
                  id_stall       = ~bus.if_ready;
               end
            end
            HAZARD: id_stall = 1'b1;
            PENDING: begin
               redirect_valid = 1'b1;
               redirect_addr  = pend_addr;
               id_stall       = ~bus.if_ready;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 1'b0;
         pend_addr <= 32'd0;
         taken_cnt <= 16'd0;
         stall_cnt <= 16'd0;
      end else if (bus.flush) begin
         state <= IDLE;
         cnt   <= 1'b0;
      end else begin
         if (id_stall)                      stall_cnt <= stall_cnt + 16'd1;
         if (redirect_valid && bus.if_ready) taken_cnt <= taken_cnt + 16'd1;
         case (state)
            IDLE: begin
               if (need == 2'd2) begin
                  state <= HAZARD;
                  cnt   <= 1'b1;
               end else if (need == 2'd0 && is_branch && bus.branch_flag && !bus.if_ready) begin
                  pend_addr <= bus.branch_addr;
                  state     <= PENDING;
               end
            end
            HAZARD: begin
               // A one-cycle 1-bit count: the decrement to zero is the exit cycle.
               cnt <= cnt - 1'b1;
               if (cnt == 1'b1) state <= IDLE;
            end
            PENDING: if (bus.if_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.id_stall          = id_stall;
   assign bus.pc_redirect_valid = redirect_valid;
   assign bus.pc_redirect_addr  = redirect_addr;
   assign bus.taken_cnt         = taken_cnt;
   assign bus.stall_cnt         = stall_cnt;
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution sequencer for the ID stage of the 5-stage MIPS pipeline. It sits between the ID-stage branch target generator and the PC/fetch logic. It detects operand hazards on branch/jump register sources and stalls ID for the required number of cycles. It hands the resolved redirect to fetch with a ready handshake, holding it if fetch cannot accept. It also keeps wrapping performance counters for taken branches and branch stall cycles.

## Interface
- No parameters; all widths fixed (32-bit address/data, 5-bit register index).
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; overrides every other input
- flush  input  1  exception/pipeline flush; abandons any branch in progress
- id_valid  input  1  ID holds a valid instruction
- id_is_branch  input  1  ID instruction is JAL, JR, JALR, BEQ or BNE
- id_rs_addr  input  5  rs index of ID instruction
- id_rt_addr  input  5  rt index of ID instruction
- id_uses_rt  input  1  branch compares rt (BEQ/BNE only)
- ex_write  input  1  EX instruction writes a GPR
- ex_load  input  1  EX instruction is a load
- ex_write_addr  input  5  EX destination index
- mem_load  input  1  MEM instruction is a load
- mem_write_addr  input  5  MEM destination index
- branch_flag  input  1  branch/jump taken, from the target generator
- branch_addr  input  32  resolved target, from the target generator
- if_ready  input  1  fetch accepts a redirect this cycle
- id_stall  output  1  hold ID (and IF); insert bubble into EX
- pc_redirect_valid  output  1  redirect request to PC
- pc_redirect_addr  output  32  redirect target
- taken_cnt  output  16  taken branches accepted by fetch, wraps
- stall_cnt  output  16  cycles id_stall was high, wraps

## Operation
- Branch source match: src = rs, or rt when id_uses_rt. A match requires a nonzero index. Register 0 never matches.
- Required stall n. Start from n = 0.
  - If ex_load and EX destination matches a source: n = 2.
  - Otherwise, if ex_write and EX destination matches a source: n = 1.
  - Independently, if mem_load and MEM destination matches a source: n = max(n, 1).
- Hazard checks apply only when id_valid & id_is_branch.
- States: IDLE, HAZARD, PENDING. 2-bit state, 1-bit counter cnt, 32-bit pend_addr.
- IDLE, branch in ID, n>0:
  - id_stall=1 and no redirect.
  - If n=2, go to HAZARD with cnt=1. If n=1, stay IDLE; the hazard is re-evaluated next cycle.
- IDLE, branch in ID, n=0, branch_flag=1, if_ready=1:
  - pc_redirect_valid=1 and pc_redirect_addr=branch_addr, combinationally.
  - id_stall=0; taken_cnt+1.
- IDLE, branch in ID, n=0, branch_flag=1, if_ready=0:
  - id_stall=1 and pc_redirect_valid=1 with branch_addr.
  - Latch pend_addr=branch_addr and go to PENDING.
- IDLE, n=0, branch_flag=0 (not-taken branch or non-branch): all outputs idle; stay IDLE.
- HAZARD: id_stall=1 and no redirect. cnt decrements; when cnt reaches 0, go to IDLE. The branch is then re-evaluated with fresh EX/MEM inputs.
- PENDING: pc_redirect_valid=1 with pc_redirect_addr=pend_addr. ID inputs are ignored.
  - if_ready=0: id_stall=1; stay.
  - if_ready=1: id_stall=0; taken_cnt+1; go to IDLE.
- pc_redirect_addr is 0 whenever pc_redirect_valid=0.
- stall_cnt increments on every cycle with id_stall=1. Both counters wrap 0xFFFF→0x0000.
- flush=1 (rst=0), any state:
  - id_stall=0, pc_redirect_valid=0, pc_redirect_addr=0.
  - Next state IDLE, cnt=0, pend_addr kept.
  - Counters do not increment that cycle.
- The delay slot is never cancelled. The instruction in IF when the redirect is accepted executes.

## Timing
- Reset values: state=IDLE, cnt=0, pend_addr=0, taken_cnt=0, stall_cnt=0. Outputs evaluate to id_stall=0, pc_redirect_valid=0, pc_redirect_addr=0.
- Hazard-free taken branch with if_ready=1 redirects in the same cycle: 0-cycle latency, no stall.
- EX-load hazard stalls 2 cycles; EX-ALU or MEM-load hazard stalls 1 cycle. Redirect comes on the following evaluation cycle at the earliest.
- pc_redirect_valid stays high, with a stable address, from the first cycle until the cycle if_ready=1 (inclusive). It drops the cycle after.
- Simultaneous if_ready=1 and flush=1 in PENDING: flush wins; no redirect and no taken_cnt increment.
- rst mid-HAZARD or mid-PENDING: next cycle in reset state; the redirect is lost.
- Counter increments are registered; they are visible the cycle after the event.

## Test plan
- Reset, then BEQ, no hazard, branch_flag=1, branch_addr=0x0000_0040, if_ready=1 -> redirect valid same cycle with 0x40; id_stall=0; taken_cnt=1 next cycle.
- BNE with rs=5; EX is a load to $5 -> id_stall high 2 cycles; stall_cnt=2. Third cycle no hazard, redirect issued.
- JR rs=0 with EX writing $0 -> no stall; redirect to branch_addr.
- Taken branch to 0x1000_0000 with if_ready=0 for 3 cycles -> valid and address held 4 cycles, id_stall high 3 cycles; single taken_cnt increment on the accept cycle.
- flush during PENDING with if_ready=1 -> no redirect, state IDLE, taken_cnt unchanged.
- Preload stall_cnt to 0xFFFF via continuous hazards; one more stall cycle -> 0x0000.
